// File: rtl/register_scoreboard_pkg.sv
// Shared sizing defaults and helpers for the register scoreboard.
// Counters saturate at sb_max(CW); the top and counter derive their limit from it.
package register_scoreboard_pkg;

  localparam int unsigned DefWRd  = 5;
  localparam int unsigned DefNReg = 32;
  localparam int unsigned DefCw   = 2;

  function automatic int unsigned sb_max(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

  localparam int unsigned DefMax = sb_max(DefCw);

endpackage

// File: rtl/register_scoreboard_if.sv
// Decode / writeback / kill bus of the register scoreboard.
// Master drives the requests; slave (the scoreboard) returns hazard and status.
interface register_scoreboard_if
  import register_scoreboard_pkg::*;
#(
  parameter int unsigned W_RD  = DefWRd,
  parameter int unsigned N_REG = DefNReg,
  parameter int unsigned CW    = DefCw
) ();

  logic                 chk_v_i;
  logic [W_RD-1:0]      chk_r0_i;
  logic [W_RD-1:0]      chk_r1_i;
  logic                 chk_use_r1_i;
  logic                 reserved_o;
  logic                 set_v_i;
  logic [W_RD-1:0]      set_r_i;
  logic                 wb_v_i;
  logic [W_RD-1:0]      wb_r_i;
  logic                 kill_v_i;
  logic [W_RD-1:0]      kill_r_i;
  logic [N_REG-1:0]     busy_o;
  logic [W_RD+CW-1:0]   outstanding_o;
  logic                 err_o;

  modport master (
    output chk_v_i, chk_r0_i, chk_r1_i, chk_use_r1_i,
    output set_v_i, set_r_i, wb_v_i, wb_r_i, kill_v_i, kill_r_i,
    input  reserved_o, busy_o, outstanding_o, err_o
  );

  modport slave (
    input  chk_v_i, chk_r0_i, chk_r1_i, chk_use_r1_i,
    input  set_v_i, set_r_i, wb_v_i, wb_r_i, kill_v_i, kill_r_i,
    output reserved_o, busy_o, outstanding_o, err_o
  );

endinterface

// File: rtl/register_scoreboard_counter.sv
// One register's pending-write counter: +1 on reserve, -0..2 on release.
// Overflowing sets are dropped and underflows clamp to zero; both flag err_o for a cycle.
module sb_counter
  import register_scoreboard_pkg::*;
#(
  parameter int unsigned CW = DefCw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_i,
  input  logic [1:0]    dec_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_next_o,
  output logic          err_o
);

  localparam logic [CW-1:0] Max = CW'(sb_max(CW));

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   up;

  always_comb begin
    err_o = 1'b0;
    up    = {1'b0, cnt_q};
    if (inc_i) begin
      if (cnt_q == Max) begin
        err_o = 1'b1;
      end else begin
        up = up + (CW+1)'(1);
      end
    end
    if (up < (CW+1)'(dec_i)) begin
      cnt_d = '0;
      err_o = 1'b1;
    end else begin
      cnt_d = CW'(up - (CW+1)'(dec_i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard: per-register pending-write counters plus decode hazard check.
// Hazards look only at registered counts, so a release is seen by decode one cycle later.
module register_scoreboard
  import register_scoreboard_pkg::*;
#(
  parameter int unsigned W_RD     = DefWRd,
  parameter int unsigned N_REG    = DefNReg,
  parameter int unsigned CW       = DefCw,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  register_scoreboard_if.slave  bus
);

  localparam logic [CW-1:0] Max = CW'(sb_max(CW));
  localparam int unsigned   OW  = W_RD + CW;

  logic [N_REG-1:0] inc;
  logic [1:0]       dec     [N_REG];
  logic [CW-1:0]    cnt     [N_REG];
  logic [CW-1:0]    cnt_nxt [N_REG];
  logic [N_REG-1:0] cnt_err;

  logic [OW-1:0] outstanding_q, outstanding_d;
  logic          err_q, err_d;

  // Index decode; register 0 is invisible to all three buses when hardwired.
  always_comb begin
    for (int unsigned i = 0; i < N_REG; i++) begin
      logic ok;
      ok     = !(ZERO_REG && (i == 0));
      inc[i] = ok && bus.set_v_i && (bus.set_r_i == W_RD'(i));
      dec[i] = {1'b0, ok && bus.wb_v_i && (bus.wb_r_i == W_RD'(i))}
             + {1'b0, ok && bus.kill_v_i && (bus.kill_r_i == W_RD'(i))};
    end
  end

  for (genvar g = 0; g < N_REG; g++) begin : g_cnt
    sb_counter #(
      .CW (CW)
    ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (inc[g]),
      .dec_i      (dec[g]),
      .cnt_o      (cnt[g]),
      .cnt_next_o (cnt_nxt[g]),
      .err_o      (cnt_err[g])
    );
  end

  always_comb begin
    logic [CW-1:0] c0, c1;
    logic          m0, m1, hz0, hz1, full0;
    c0    = cnt[bus.chk_r0_i];
    c1    = cnt[bus.chk_r1_i];
    m0    = ZERO_REG && (bus.chk_r0_i == '0);
    m1    = ZERO_REG && (bus.chk_r1_i == '0);
    hz0   = !m0 && (c0 != '0);
    hz1   = !m1 && (c1 != '0);
    full0 = !m0 && (c0 == Max);
    bus.reserved_o = bus.chk_v_i && (hz0 || (bus.chk_use_r1_i && hz1) || full0);
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REG; i++) begin
      bus.busy_o[i] = |cnt[i];
    end
  end

  // Sum the next-state counts so the registered total lines up with busy_o.
  always_comb begin
    outstanding_d = '0;
    for (int unsigned i = 0; i < N_REG; i++) begin
      outstanding_d = outstanding_d + OW'(cnt_nxt[i]);
    end
    err_d = err_q | (|cnt_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign bus.outstanding_o = outstanding_q;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench: a cycle table with expected post-edge state queued per row,
// followed by directed sequences for underflow, kill, hardwired zero and async reset.
module tb_register_scoreboard;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  register_scoreboard_if sb  ();
  register_scoreboard_if sbz ();

  register_scoreboard u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb.slave)
  );

  register_scoreboard #(
    .ZERO_REG (1'b1)
  ) u_dut_z (
    .clk   (clk),
    .reset (reset),
    .bus   (sbz.slave)
  );

  typedef struct {
    logic       sv;  logic [4:0] sr;
    logic       wv;  logic [4:0] wr;
    logic       kv;  logic [4:0] kr;
    logic       cv;  logic [4:0] r0;  logic [4:0] r1;  logic u;
    logic       res;
    logic [6:0] out; logic [31:0] busy; logic err;
  } vec_t;

  typedef struct {
    logic [6:0] out; logic [31:0] busy; logic err;
  } post_t;

  vec_t  vecs [$];
  post_t sbq  [$];
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic vec_t mk(input logic sv, input int sr, input logic wv, input int wr,
                              input logic kv, input int kr, input logic cv, input int r0,
                              input int r1, input logic u, input logic res, input int out,
                              input logic [31:0] busy, input logic err);
    vec_t v;
    v.sv = sv; v.sr = 5'(sr); v.wv = wv; v.wr = 5'(wr); v.kv = kv; v.kr = 5'(kr);
    v.cv = cv; v.r0 = 5'(r0); v.r1 = 5'(r1); v.u = u; v.res = res;
    v.out = 7'(out); v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    sb.chk_v_i = 0;  sb.chk_r0_i = 0;  sb.chk_r1_i = 0;  sb.chk_use_r1_i = 0;
    sb.set_v_i = 0;  sb.set_r_i = 0;   sb.wb_v_i = 0;    sb.wb_r_i = 0;
    sb.kill_v_i = 0; sb.kill_r_i = 0;
    sbz.chk_v_i = 0; sbz.chk_r0_i = 0; sbz.chk_r1_i = 0; sbz.chk_use_r1_i = 0;
    sbz.set_v_i = 0; sbz.set_r_i = 0;  sbz.wb_v_i = 0;   sbz.wb_r_i = 0;
    sbz.kill_v_i = 0; sbz.kill_r_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between edges; returns 1ns after the next posedge.
  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic check_state(input string tag, input int out, input logic [31:0] busy,
                             input logic err);
    check({tag, ".outstanding"}, 32'(sb.outstanding_o), 32'(out));
    check({tag, ".busy"}, sb.busy_o, busy);
    check({tag, ".err"}, 32'(sb.err_o), 32'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    post_t p;
    vec_t  v;
    clear_all();
    sb.chk_v_i = 1; sb.chk_r0_i = 3; sb.chk_r1_i = 4; sb.chk_use_r1_i = 1;
    #12;
    check("reset.reserved", 32'(sb.reserved_o), 0);
    check_state("reset", 0, 0, 0);
    reset = 1'b1;
    tick();

    //       sv sr wv wr kv kr cv r0 r1 u  res out busy     err
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 4, 1, 0, 0, 32'h0,  0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 1, 3, 4, 1, 0, 1, 32'h20, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 5, 1, 1, 1, 32'h20, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 5, 0, 0, 1, 32'h20, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h20, 0));
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 1, 5, 0, 0, 1, 1, 32'h20, 0));
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 1, 5, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 32'h0,  0));
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0));
    vecs.push_back(mk(1, 7, 1, 7, 0, 0, 1, 7, 0, 0, 1, 1, 32'h80, 0));
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h80, 0));
    vecs.push_back(mk(0, 0, 1, 7, 1, 7, 1, 7, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h0,  0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4,  0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h4,  0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 1, 2, 0, 0, 1, 3, 32'h4,  0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 1, 2, 0, 0, 1, 3, 32'h4,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 2, 1, 1, 3, 32'h4,  1));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2, 32'h4,  1));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4,  1));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 1, 0, 2, 1, 1, 0, 32'h0,  1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 32'h0,  1));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      sb.set_v_i = v.sv;  sb.set_r_i = v.sr;  sb.wb_v_i = v.wv;  sb.wb_r_i = v.wr;
      sb.kill_v_i = v.kv; sb.kill_r_i = v.kr; sb.chk_v_i = v.cv; sb.chk_r0_i = v.r0;
      sb.chk_r1_i = v.r1; sb.chk_use_r1_i = v.u;
      #1;
      check($sformatf("row%0d.reserved", i), 32'(sb.reserved_o), 32'(v.res));
      p.out = v.out; p.busy = v.busy; p.err = v.err;
      sbq.push_back(p);
      tick();
      p = sbq.pop_front();
      check_state($sformatf("row%0d", i), 32'(p.out), p.busy, p.err);
    end

    // Release of an idle register is an underflow.
    clear_all();
    pulse_reset();
    check_state("uflow.pre", 0, 0, 0);
    sb.wb_v_i = 1; sb.wb_r_i = 9;
    tick();
    clear_all();
    check_state("uflow", 0, 0, 1);

    // Kill alone releases a reservation.
    pulse_reset();
    sb.set_v_i = 1; sb.set_r_i = 4;
    tick();
    clear_all();
    sb.kill_v_i = 1; sb.kill_r_i = 4;
    #1;
    check("kill.busy_pre", sb.busy_o, 32'h10);
    tick();
    clear_all();
    check_state("kill", 0, 0, 0);

    // Hardwired register 0.
    sbz.set_v_i = 1; sbz.set_r_i = 0;
    tick();
    clear_all();
    sbz.chk_v_i = 1; sbz.chk_r0_i = 0; sbz.chk_r1_i = 0; sbz.chk_use_r1_i = 1;
    #1;
    check("zero.reserved", 32'(sbz.reserved_o), 0);
    check("zero.busy", sbz.busy_o, 0);
    check("zero.outstanding", 32'(sbz.outstanding_o), 0);
    sbz.wb_v_i = 1; sbz.wb_r_i = 0;
    tick();
    sbz.wb_v_i = 0; sbz.set_v_i = 1; sbz.set_r_i = 3;
    tick();
    clear_all();
    check("zero.err", 32'(sbz.err_o), 0);
    sbz.chk_v_i = 1; sbz.chk_r0_i = 3;
    #1;
    check("zero.r3_reserved", 32'(sbz.reserved_o), 1);
    check("zero.r3_outstanding", 32'(sbz.outstanding_o), 1);

    // Asynchronous reset with four writes outstanding.
    clear_all();
    for (int i = 0; i < 4; i++) begin
      sb.set_v_i = 1; sb.set_r_i = (i < 2) ? 5'd1 : 5'd8;
      tick();
    end
    clear_all();
    sb.chk_v_i = 1; sb.chk_r0_i = 1;
    #1;
    check("areset.pre_reserved", 32'(sb.reserved_o), 1);
    check_state("areset.pre", 4, 32'h102, 0);
    #2;
    reset = 1'b0;
    #1;
    check("areset.reserved", 32'(sb.reserved_o), 0);
    check_state("areset", 0, 0, 0);
    check("areset.z_outstanding", 32'(sbz.outstanding_o), 0);
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
